// File: rtl/fpu_issue_pkg.sv
// Shared constants and default-width command/result records for the FPU issue front end.
// FPU_ISSUE_EXC_FLAG_EN adds a per-result infinity/NaN flag.
package fpu_issue_pkg;
   localparam int         FPU_LAT      = 2;
   localparam int         FP_W         = 32;
   localparam int         DEF_TAG_W    = 4;
   localparam logic [7:0] EXP_ALL_ONES = 8'hFF;
   localparam logic       OP_ADD       = 1'b0;
   localparam logic       OP_MUL       = 1'b1;

   typedef struct packed {
      logic [FP_W-1:0]      a;
      logic [FP_W-1:0]      b;
      logic                 op;
      logic [DEF_TAG_W-1:0] tag;
   } cmd_t;

   typedef struct packed {
      logic [FP_W-1:0]      data;
      logic [DEF_TAG_W-1:0] tag;
      logic                 op;
`ifdef FPU_ISSUE_EXC_FLAG_EN
      logic                 exc;
`endif
   } res_t;

   // Exponent all ones covers both infinity and NaN.
   function automatic logic is_exc(input logic [FP_W-1:0] v);
      return v[30:23] == EXP_ALL_ONES;
   endfunction
endpackage

// File: rtl/fpu_issue_fifo.sv
// Synchronous FIFO with occupancy count; head reads as zero while empty.
module fpu_issue_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok, pop_ok;

   assign push_ok = i_push && (count_q != CNT_MAX);
   assign pop_ok  = i_pop && (count_q != '0);
   assign o_data  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign o_count = count_q;

   always_ff @(posedge i_clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (push_ok && !pop_ok)      count_q <= count_q + CNT_ONE;
         else if (pop_ok && !push_ok) count_q <= count_q - CNT_ONE;
      end
   end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// Credit-limited command issue and in-order result return around a fixed-latency FPU.
// FPU_ISSUE_EXC_FLAG_EN adds o_res_exc (infinity/NaN flag per result).
module fpu_issue_ctrl
   import fpu_issue_pkg::*;
#(
   parameter int CMD_DEPTH = 4,
   parameter int RES_DEPTH = 4,
   parameter int TAG_W     = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [FP_W-1:0]  i_cmd_a,
   input  logic [FP_W-1:0]  i_cmd_b,
   input  logic             i_cmd_op,
   input  logic [TAG_W-1:0] i_cmd_tag,
   output logic [FP_W-1:0]  o_fpu_data_1,
   output logic [FP_W-1:0]  o_fpu_data_2,
   output logic             o_fpu_op,
   output logic             o_fpu_data_valid,
   input  logic [FP_W-1:0]  i_fpu_data_out,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic [FP_W-1:0]  o_res_data,
   output logic [TAG_W-1:0] o_res_tag,
   output logic             o_res_op,
   output logic             o_busy
`ifdef FPU_ISSUE_EXC_FLAG_EN
   ,
   output logic             o_res_exc
`endif
);
   localparam int CCW = $clog2(CMD_DEPTH) + 1;
   localparam int RCW = $clog2(RES_DEPTH) + 1;
   localparam int IFW = $clog2(FPU_LAT + 1);
   localparam logic [CCW-1:0] CMD_FULL = CMD_DEPTH[CCW-1:0];
   localparam logic [RCW:0]   RES_CAP  = RES_DEPTH[RCW:0];

   // Same layout as the package records, widened to this instance's TAG_W.
   typedef struct packed {
      logic [FP_W-1:0]  a;
      logic [FP_W-1:0]  b;
      logic             op;
      logic [TAG_W-1:0] tag;
   } cmd_ent_t;

   typedef struct packed {
      logic [FP_W-1:0]  data;
      logic [TAG_W-1:0] tag;
      logic             op;
`ifdef FPU_ISSUE_EXC_FLAG_EN
      logic             exc;
`endif
   } res_ent_t;

   typedef struct packed {
      logic             valid;
      logic             op;
      logic [TAG_W-1:0] tag;
   } trk_t;

   cmd_ent_t       cmd_in, cmd_head;
   res_ent_t       res_in, res_head;
   logic [CCW-1:0] cmd_count;
   logic [RCW-1:0] res_count;
   logic           rdy_en_q;
   logic           cmd_push, issue, res_push, res_pop;
   logic [IFW-1:0] inflight;
   logic [RCW:0]   occupancy;
   trk_t           trk_q [FPU_LAT];
   trk_t           trk_d [FPU_LAT];

   // Ready stays low through reset and rises on the first edge after release.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rdy_en_q <= 1'b0;
      else          rdy_en_q <= 1'b1;
   end

   assign o_cmd_ready = rdy_en_q && (cmd_count != CMD_FULL);
   assign cmd_push    = i_cmd_valid && o_cmd_ready;

   always_comb begin
      cmd_in     = '0;
      cmd_in.a   = i_cmd_a;
      cmd_in.b   = i_cmd_b;
      cmd_in.op  = i_cmd_op;
      cmd_in.tag = i_cmd_tag;
   end

   fpu_issue_fifo #(.WIDTH($bits(cmd_ent_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (cmd_push),
      .i_data  (cmd_in),
      .i_pop   (issue),
      .o_data  (cmd_head),
      .o_count (cmd_count)
   );

   always_comb begin
      inflight = '0;
      for (int i = 0; i < FPU_LAT; i++) inflight = inflight + IFW'(trk_q[i].valid);
   end

   // Every issued command must already own a result slot, since the FPU cannot stall.
   assign occupancy        = {1'b0, res_count} + (RCW+1)'(inflight);
   assign issue            = (cmd_count != '0) && (occupancy < RES_CAP);
   assign o_fpu_data_valid = issue;
   assign o_fpu_data_1     = cmd_head.a;
   assign o_fpu_data_2     = cmd_head.b;
   assign o_fpu_op         = trk_q[0].op;

   always_comb begin
      trk_d[0] = '0;
      if (issue) begin
         trk_d[0].valid = 1'b1;
         trk_d[0].op    = cmd_head.op;
         trk_d[0].tag   = cmd_head.tag;
      end
      for (int i = 1; i < FPU_LAT; i++) trk_d[i] = trk_q[i-1];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < FPU_LAT; i++) trk_q[i] <= '0;
      end else begin
         for (int i = 0; i < FPU_LAT; i++) trk_q[i] <= trk_d[i];
      end
   end

   assign res_push = trk_q[FPU_LAT-1].valid;

   always_comb begin
      res_in      = '0;
      res_in.data = i_fpu_data_out;
      res_in.tag  = trk_q[FPU_LAT-1].tag;
      res_in.op   = trk_q[FPU_LAT-1].op;
`ifdef FPU_ISSUE_EXC_FLAG_EN
      res_in.exc  = is_exc(i_fpu_data_out);
`endif
   end

   fpu_issue_fifo #(.WIDTH($bits(res_ent_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (res_push),
      .i_data  (res_in),
      .i_pop   (res_pop),
      .o_data  (res_head),
      .o_count (res_count)
   );

   assign o_res_valid = (res_count != '0);
   assign res_pop     = o_res_valid && i_res_ready;
   assign o_res_data  = res_head.data;
   assign o_res_tag   = res_head.tag;
   assign o_res_op    = res_head.op;
`ifdef FPU_ISSUE_EXC_FLAG_EN
   assign o_res_exc   = res_head.exc;
`endif

   assign o_busy = (cmd_count != '0) || (inflight != '0) || (res_count != '0);
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl with a stand-in 2-cycle FPU; honours FPU_ISSUE_EXC_FLAG_EN.
module tb_fpu_issue_ctrl;
   localparam int RES_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_a = '0, cmd_b = '0;
   logic        cmd_op = 1'b0;
   logic [3:0]  cmd_tag = '0;
   logic [31:0] fpu_d1, fpu_d2;
   logic        fpu_op, fpu_dv;
   logic [31:0] fpu_out = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic [3:0]  res_tag;
   logic        res_op;
   logic        busy;
`ifdef FPU_ISSUE_EXC_FLAG_EN
   logic        res_exc;
`endif

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.CMD_DEPTH(4), .RES_DEPTH(RES_DEPTH), .TAG_W(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
      .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_op(cmd_op), .i_cmd_tag(cmd_tag),
      .o_fpu_data_1(fpu_d1), .o_fpu_data_2(fpu_d2), .o_fpu_op(fpu_op),
      .o_fpu_data_valid(fpu_dv), .i_fpu_data_out(fpu_out),
      .o_res_valid(res_valid), .i_res_ready(res_ready),
      .o_res_data(res_data), .o_res_tag(res_tag), .o_res_op(res_op),
      .o_busy(busy)
`ifdef FPU_ISSUE_EXC_FLAG_EN
      , .o_res_exc(res_exc)
`endif
   );

   // Stand-in FPU: exact answers for the planned float pairs, an integer mix otherwise.
   function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b, input logic op);
      if (!op && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
      if ( op && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
      if (!op && a == 32'h7F800000 && b == 32'h3F800000) return 32'h7F800000;
      return op ? (a ^ b) : (a + b);
   endfunction

   logic [31:0] fa_q = '0, fb_q = '0;
   always @(posedge clk) begin
      if (fpu_dv) begin
         fa_q <= fpu_d1;
         fb_q <= fpu_d2;
      end
      fpu_out <= fpu_model(fa_q, fb_q, fpu_op);
   end

   int n_vec = 0;
   int n_bad = 0;
   int issue_cnt = 0;
   int rv_seen = 0;

   typedef struct { logic [31:0] d; logic [3:0] t; logic o; } got_t;
   got_t got_q[$];

   always @(posedge clk) begin
      if (fpu_dv) issue_cnt++;
      if (res_valid) rv_seen++;
      if (res_valid && res_ready) got_q.push_back('{res_data, res_tag, res_op});
      if (rst_n && dut.res_push && dut.res_count == 3'(RES_DEPTH) && !(res_valid && res_ready)) begin
         n_bad++;
         $display("FAIL res_overflow: push into full result fifo at %0t", $time);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input logic [3:0] tag);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
      for (int k = 0; k < 64 && !ok; k++) begin
         ok = cmd_ready;
         @(posedge clk);
         if (!ok) @(negedge clk);
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      while (busy && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk(nm, {31'd0, busy}, 32'd0);
   endtask

   typedef struct { logic [31:0] a; logic [31:0] b; logic op; logic [3:0] tag; logic [31:0] exp; } vec_t;
   vec_t vecs[5];

   initial begin
      int lat, base;
      vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 4'h3, 32'h40400000};
      vecs[1] = '{32'h40000000, 32'h40400000, 1'b1, 4'h2, 32'h40C00000};
      vecs[2] = '{32'h7F800000, 32'h3F800000, 1'b0, 4'h5, 32'h7F800000};
      vecs[3] = '{32'h12345678, 32'h00000001, 1'b1, 4'hF, 32'h12345679};
      vecs[4] = '{32'h0000FFFF, 32'h00000001, 1'b0, 4'h9, 32'h00010000};

      // Reset values, including ready held low.
      repeat (3) @(negedge clk);
      chk("rst_cmd_ready", {31'd0, cmd_ready}, 0);
      chk("rst_fpu_d1", fpu_d1, 0);
      chk("rst_fpu_d2", fpu_d2, 0);
      chk("rst_fpu_op", {31'd0, fpu_op}, 0);
      chk("rst_fpu_dv", {31'd0, fpu_dv}, 0);
      chk("rst_res_valid", {31'd0, res_valid}, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_tag", {28'd0, res_tag}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      rst_n = 1'b1;
      #1 chk("rel_ready_before_edge", {31'd0, cmd_ready}, 0);
      @(negedge clk);
      chk("rel_ready", {31'd0, cmd_ready}, 1);
      chk("rel_busy", {31'd0, busy}, 0);

      // Single commands: latency, pass-through and tag/op return.
      res_ready = 1'b1;
      for (int v = 0; v < 5; v++) begin
         base = issue_cnt;
         send(vecs[v].a, vecs[v].b, vecs[v].op, vecs[v].tag);
         idle();
         chk($sformatf("v%0d_strobe", v), {31'd0, fpu_dv}, 1);
         lat = 1;
         while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         chk($sformatf("v%0d_latency", v), lat, 4);
         chk($sformatf("v%0d_data", v), res_data, vecs[v].exp);
         chk($sformatf("v%0d_tag", v), {28'd0, res_tag}, {28'd0, vecs[v].tag});
         chk($sformatf("v%0d_op", v), {31'd0, res_op}, {31'd0, vecs[v].op});
`ifdef FPU_ISSUE_EXC_FLAG_EN
         chk($sformatf("v%0d_exc", v), {31'd0, res_exc}, {31'd0, (vecs[v].exp[30:23] == 8'hFF)});
`endif
         wait_idle($sformatf("v%0d_idle", v));
         chk($sformatf("v%0d_issues", v), issue_cnt - base, 1);
      end

      // Back-to-back add then multiply.
      got_q.delete();
      send(32'h3F800000, 32'h40000000, 1'b0, 4'h1);
      send(32'h40000000, 32'h40400000, 1'b1, 4'h2);
      idle();
      chk("b2b_op_first", {31'd0, fpu_op}, 0);
      chk("b2b_strobe_second", {31'd0, fpu_dv}, 1);
      @(negedge clk);
      chk("b2b_op_second", {31'd0, fpu_op}, 1);
      wait_idle("b2b_idle");
      chk("b2b_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("b2b_r0_data", got_q[0].d, 32'h40400000);
         chk("b2b_r0_tag", {28'd0, got_q[0].t}, 1);
         chk("b2b_r1_data", got_q[1].d, 32'h40C00000);
         chk("b2b_r1_tag", {28'd0, got_q[1].t}, 2);
         chk("b2b_r1_op", {31'd0, got_q[1].o}, 1);
      end

      // Backpressure: only RES_DEPTH issue, then the command fifo fills.
      @(negedge clk);
      res_ready = 1'b0;
      got_q.delete();
      base = issue_cnt;
      for (int i = 0; i < 8; i++) send(32'h100 * i, i, i[0], 4'(i));
      idle();
      repeat (6) @(negedge clk);
      chk("bp_issues", issue_cnt - base, RES_DEPTH);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 0);
      chk("bp_res_valid", {31'd0, res_valid}, 1);
      res_ready = 1'b1;
      wait_idle("bp_idle");
      chk("bp_count", got_q.size(), 8);
      for (int i = 0; i < 8 && i < got_q.size(); i++) begin
         chk($sformatf("bp_tag%0d", i), {28'd0, got_q[i].t}, i);
         chk($sformatf("bp_data%0d", i), got_q[i].d, fpu_model(32'h100 * i, i, i[0]));
      end

      // Reset with results stored, in flight and queued.
      @(negedge clk);
      res_ready = 1'b0;
      for (int i = 8; i < 14; i++) send(32'h55 + i, i, 1'b0, 4'(i));
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("mid_busy_before", {31'd0, busy}, 1);
      #2 rst_n = 1'b0;
      #1 chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_ready", {31'd0, cmd_ready}, 0);
      chk("mid_rst_res_valid", {31'd0, res_valid}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      res_ready = 1'b1;
      rv_seen = 0;
      repeat (10) @(negedge clk);
      chk("mid_no_results", rv_seen, 0);
      chk("mid_busy_after", {31'd0, busy}, 0);
      chk("mid_ready_after", {31'd0, cmd_ready}, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish by %0t", $time);
      $fatal(1);
   end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Command-side front end for the `fpu` datapath. It buffers operand/op commands from a valid/ready producer and issues them to the FPU back to back. It tracks each command through the FPU's fixed 2-cycle latency and returns tagged results in order through a valid/ready consumer port. The FPU cannot stall, so issue is credit-limited: every in-flight result is guaranteed a slot in the result buffer.

## Interface
- CMD_DEPTH, 4: command FIFO entries; power of two, ≥2.
- RES_DEPTH, 4: result FIFO entries; power of two, ≥2.
- TAG_W, 4: width of the opaque command tag.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  command FIFO not full.
- i_cmd_a, i_cmd_b  in  32  IEEE-754 single operands.
- i_cmd_op  in  1  0 = add, 1 = multiply.
- i_cmd_tag  in  TAG_W  returned unchanged with the result.
- o_fpu_data_1, o_fpu_data_2  out  32  operands to the FPU.
- o_fpu_op  out  1  op of the command latched inside the FPU.
- o_fpu_data_valid  out  1  issue strobe.
- i_fpu_data_out  in  32  FPU result register.
- o_res_valid  out  1  result FIFO not empty.
- i_res_ready  in  1  consumer accepts.
- o_res_data  out  32  result word.
- o_res_tag  out  TAG_W  result tag.
- o_res_op  out  1  op that produced the result.
- o_busy  out  1  any command queued, in flight, or unread.

## Operation
- Accept: a command is written when i_cmd_valid && o_cmd_ready. o_cmd_ready = (cmd_count != CMD_DEPTH). It depends only on occupancy; a same-cycle pop does not raise it.
- Issue condition: cmd FIFO non-empty && (res_count + inflight) < RES_DEPTH. inflight = number of set bits in the 2-stage valid pipe.
- o_fpu_data_1/2 are driven combinationally from the cmd FIFO head. o_fpu_data_valid equals the issue condition. The head is popped on that edge.
- Tracking pipe: stage0 ← {valid, op, tag} of the issued command; stage1 ← stage0 every cycle. Bubbles shift through as invalid.
- o_fpu_op = stage0.op. The FPU evaluates with the op of the operands it latched on the previous edge, which is what makes back-to-back mixed ops correct. o_fpu_op = 0 when stage0 is invalid.
- Capture: on any edge where stage1 is valid, {i_fpu_data_out, stage1.tag, stage1.op} is pushed into the result FIFO. Overflow is impossible by construction. Bench asserts on it.
- Drain: pop on o_res_valid && i_res_ready. Results leave in issue order.
- Simultaneous push and pop on either FIFO: both take effect and the count is unchanged. Pointers wrap modulo depth.
- o_busy = cmd_count != 0 || inflight != 0 || res_count != 0.
- No arithmetic or special-value handling is done here. Results pass through bit-exact.

## Timing
- Reset (asynchronous, any time): FIFOs emptied, pipe cleared, in-flight results discarded. o_cmd_ready = 0 while i_rst_n = 0, and 1 from the first edge after release. All other outputs = 0.
- Command accepted at edge A → earliest issue strobe in cycle A..A+1 (head visible after A) → stage0 at A+1 → stage1 at A+2 → result captured at A+3 → o_res_valid high in the cycle after A+3.
- Throughput: one command per cycle while neither FIFO blocks.
- With i_res_ready held low, exactly RES_DEPTH commands issue, then issue stops. Queued commands remain and o_cmd_ready falls once the cmd FIFO is full.

## Configuration
- FPU_ISSUE_EXC_FLAG_EN defined:
  - Adds output o_res_exc (1 bit), stored per result entry.
  - o_res_exc = (result[30:23] == 8'hFF), i.e. infinity or NaN.
  - Reset value 0.
- FPU_ISSUE_EXC_FLAG_EN undefined: port and storage bit are absent. Behaviour is otherwise identical.

## Structure
- Package fpu_issue_pkg holds:
  - FPU_LAT = 2
  - FP_W = 32
  - EXP_ALL_ONES = 8'hFF
  - OP_ADD / OP_MUL constants
  - a packed command typedef {a, b, op, tag} and a result typedef {data, tag, op[, exc]}.
- One sub-module: fpu_issue_fifo, a parameterized (WIDTH, DEPTH) synchronous FIFO with count output and async active-low reset. It is instantiated twice.

## Test plan
- Reset: hold i_rst_n = 0 → every output 0, including o_cmd_ready. Release → o_cmd_ready = 1, o_busy = 0.
- Single add: a=0x3F800000, b=0x40000000, op=0, tag=3 → one issue strobe; result 0x40400000 with tag 3, op 0, four cycles after acceptance.
- Back-to-back mixed ops, consecutive cycles:
  - tag1: add 0x3F800000 + 0x40000000; tag2: mul 0x40000000 × 0x40400000.
  - Required: o_fpu_op reads 0 then 1 on consecutive cycles.
  - Required results, in order: 0x40400000 (tag1), then 0x40C00000 (tag2).
- Backpressure: i_res_ready = 0, offer 8 commands with tags 0–7 → exactly 4 issue strobes, o_cmd_ready low after 8 accepts. Raise i_res_ready → tags 0–7 drain in order with no loss.
- Exception flag (macro defined): add 0x7F800000 + 0x3F800000 → o_res_exc = 1 on that result, 0 on a normal result.
- Reset mid-flight: assert i_rst_n with 2 commands in flight and 2 queued → o_res_valid never asserts for them after release, and o_busy = 0.
